// File: rtl/serial_frame_pkg.sv
// Shared constants, FSM encoding and timeout sizing for the serial frame decoder.
package serial_frame_pkg;

  localparam logic [7:0] SOF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_EMIT
  } state_t;

  // Silence limit in clock cycles; 64-bit math because bytes*10*clock exceeds 32 bits.
  function automatic longint unsigned timeout_cycles(input longint unsigned bytes,
                                                     input longint unsigned clk_hz,
                                                     input longint unsigned baud);
    return (bytes * 64'd10 * clk_hz) / baud;
  endfunction

endpackage

// File: rtl/serial_frame_buffer.sv
// Payload store: one write port, one read port with a registered address.
module serial_frame_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data
);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] rd_addr_p0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_addr_p0 <= rd_addr;
  end

  assign rd_data = mem[rd_addr_p0];

endmodule

// File: rtl/serial_frame_decoder.sv
// Decodes A5/LEN/payload/CHK frames from a byte stream and replays the payload.
// Optional inter-byte timeout is enabled with the SERIAL_FRAME_TIMEOUT_EN macro.
module serial_frame_decoder
  import serial_frame_pkg::*;
#(
  parameter int SYSTEM_CLOCK  = 100000000,
  parameter int BAUD_RATE     = 115200,
  parameter int MAX_PAYLOAD   = 16,
  parameter int TIMEOUT_BYTES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_dv,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       err_crc,
  output logic       err_len,
  output logic       err_timeout,
  output logic       overrun
);

  localparam int IW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  state_t        state, state_nxt;
  logic [IW-1:0] idx, idx_nxt, len, len_nxt;
  logic [7:0]    sum, sum_nxt;
  logic          frame_ok_nxt, err_crc_nxt, err_len_nxt, overrun_nxt;
  logic          wr_en;
  logic [7:0]    rd_data;
  logic          timeout_hit;
  logic          is_last;

  assign is_last = (idx == len - IW'(1));

  serial_frame_buffer #(
    .DEPTH (MAX_PAYLOAD),
    .AW    (AW)
  ) u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (idx[AW-1:0]),
    .wr_data (rx_data),
    .rd_addr (idx_nxt[AW-1:0]),
    .rd_data (rd_data)
  );

`ifdef SERIAL_FRAME_TIMEOUT_EN
  localparam longint unsigned TO_CYC = timeout_cycles(longint'(TIMEOUT_BYTES),
                                                      longint'(SYSTEM_CLOCK),
                                                      longint'(BAUD_RATE));
  localparam int CW = $clog2(TO_CYC + 1);

  logic [CW-1:0] to_cnt;
  logic          waiting;

  assign waiting     = (state == ST_LEN) || (state == ST_PAYLOAD) || (state == ST_CHECK);
  // A byte arriving on the limit cycle takes priority over the timeout.
  assign timeout_hit = waiting && !rx_dv && (to_cnt == CW'(TO_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      err_timeout <= 1'b0;
    end else begin
      err_timeout <= timeout_hit;
      if (!waiting || rx_dv || timeout_hit) to_cnt <= '0;
      else                                  to_cnt <= to_cnt + CW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    len_nxt      = len;
    sum_nxt      = sum;
    frame_ok_nxt = 1'b0;
    err_crc_nxt  = 1'b0;
    err_len_nxt  = 1'b0;
    overrun_nxt  = 1'b0;
    wr_en        = 1'b0;
    case (state)
      ST_IDLE: begin
        idx_nxt = '0;
        if (rx_dv && rx_data == SOF) state_nxt = ST_LEN;
      end
      ST_LEN: begin
        if (rx_dv) begin
          if (rx_data != 8'd0 && rx_data <= 8'(MAX_PAYLOAD)) begin
            len_nxt   = IW'(rx_data);
            sum_nxt   = rx_data;
            idx_nxt   = '0;
            state_nxt = ST_PAYLOAD;
          end else begin
            err_len_nxt = 1'b1;
            state_nxt   = ST_IDLE;
          end
        end
      end
      ST_PAYLOAD: begin
        if (rx_dv) begin
          wr_en   = 1'b1;
          sum_nxt = sum + rx_data;
          if (is_last) begin
            idx_nxt   = '0;
            state_nxt = ST_CHECK;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      ST_CHECK: begin
        if (rx_dv) begin
          idx_nxt = '0;
          if (rx_data == sum) begin
            frame_ok_nxt = 1'b1;
            state_nxt    = ST_EMIT;
          end else begin
            err_crc_nxt = 1'b1;
            state_nxt   = ST_IDLE;
          end
        end
      end
      ST_EMIT: begin
        overrun_nxt = rx_dv;
        if (out_ready) begin
          if (is_last) begin
            idx_nxt   = '0;
            state_nxt = ST_IDLE;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (timeout_hit) begin
      idx_nxt   = '0;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      idx      <= '0;
      len      <= '0;
      sum      <= '0;
      frame_ok <= 1'b0;
      err_crc  <= 1'b0;
      err_len  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      len      <= len_nxt;
      sum      <= sum_nxt;
      frame_ok <= frame_ok_nxt;
      err_crc  <= err_crc_nxt;
      err_len  <= err_len_nxt;
      overrun  <= overrun_nxt;
    end
  end

  assign out_valid = (state == ST_EMIT);
  assign out_last  = out_valid && is_last;
  assign out_data  = out_valid ? rd_data : 8'h00;

endmodule

// File: tb/tb_serial_frame_decoder.sv
// Directed bench for serial_frame_decoder: vector table plus hand-written corner sequences.
module tb_serial_frame_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_dv = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_valid, out_last, frame_ok, err_crc, err_len, err_timeout, overrun;

  serial_frame_decoder #(
    .SYSTEM_CLOCK  (100000000),
    .BAUD_RATE     (115200),
    .MAX_PAYLOAD   (16),
    .TIMEOUT_BYTES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_dv       (rx_dv),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .frame_ok    (frame_ok),
    .err_crc     (err_crc),
    .err_len     (err_len),
    .err_timeout (err_timeout),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  int n_ok, n_crc, n_len, n_ovr, n_to;
  logic [7:0] got[$];
  logic       got_last[$];

  // Observation on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (frame_ok)    n_ok++;
    if (err_crc)     n_crc++;
    if (err_len)     n_len++;
    if (overrun)     n_ovr++;
    if (err_timeout) n_to++;
    if (out_valid && out_ready) begin
      got.push_back(out_data);
      got_last.push_back(out_last);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else passed++;
  endtask

  task automatic clear_obs();
    n_ok = 0; n_crc = 0; n_len = 0; n_ovr = 0; n_to = 0;
    got.delete();
    got_last.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_dv   = 1'b1;
    @(posedge clk); #1;
    rx_dv   = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct {
    string        name;
    logic [159:0] in;
    int           nin;
    logic [127:0] outb;
    int           nout;
    int           ok;
    int           crc;
    int           len;
  } vec_t;

  vec_t tv[8];

  task automatic set_vec(input int i, input string nm, input logic [159:0] in, input int nin,
                         input logic [127:0] outb, input int nout,
                         input int ok, input int crc, input int len);
    tv[i].name = nm;  tv[i].in = in;     tv[i].nin = nin;
    tv[i].outb = outb; tv[i].nout = nout;
    tv[i].ok = ok;    tv[i].crc = crc;   tv[i].len = len;
  endtask

  task automatic check_outputs(input string nm, input logic [127:0] outb, input int nout);
    chk({nm, "_count"}, 32'(got.size()), 32'(nout));
    for (int i = 0; i < nout && i < got.size(); i++) begin
      chk($sformatf("%s_data%0d", nm, i), 32'(got[i]), 32'(outb[8*(nout-1-i) +: 8]));
      chk($sformatf("%s_last%0d", nm, i), 32'(got_last[i]), 32'(i == nout - 1));
    end
  endtask

`ifdef SERIAL_FRAME_TIMEOUT_EN
  localparam longint TO = (64'd4 * 64'd10 * 64'd100000000) / 64'd115200;
`endif

  initial begin
    set_vec(0, "good", 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}), 6,
            128'({8'h11, 8'h22, 8'h33}), 3, 1, 0, 0);
    set_vec(1, "badchk", 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68}), 6,
            128'(0), 0, 0, 1, 0);
    set_vec(2, "good_after_bad", 160'({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}), 6,
            128'({8'h11, 8'h22, 8'h33}), 3, 1, 0, 0);
    set_vec(3, "len_zero", 160'({8'hA5, 8'h00}), 2, 128'(0), 0, 0, 0, 1);
    set_vec(4, "len_17", 160'({8'hA5, 8'h11}), 2, 128'(0), 0, 0, 0, 1);
    set_vec(5, "len_16", 160'({8'hA5, 8'h10,
                               8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                               8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10,
                               8'h98}), 19,
            128'({8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                  8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10}), 16, 1, 0, 0);
    set_vec(6, "noise_sof_in_payload", 160'({8'h00, 8'hFF, 8'hA5, 8'h02, 8'hA5, 8'h01, 8'hA8}), 7,
            128'({8'hA5, 8'h01}), 2, 1, 0, 0);
    set_vec(7, "sum_wrap", 160'({8'hA5, 8'h02, 8'hFF, 8'hFF, 8'h00}), 5,
            128'({8'hFF, 8'hFF}), 2, 1, 0, 0);

    // Reset state
    rst_n = 1'b0;
    idle(3);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_out_last", 32'(out_last), 32'h0);
    chk("rst_pulses", 32'({frame_ok, err_crc, err_len, err_timeout, overrun}), 32'h0);
    rst_n = 1'b1;
    idle(2);

    // Table-driven frames
    for (int v = 0; v < 8; v++) begin
      clear_obs();
      out_ready = 1'b1;
      for (int i = 0; i < tv[v].nin; i++) send_byte(tv[v].in[8*(tv[v].nin-1-i) +: 8]);
      idle(40);
      chk({tv[v].name, "_frame_ok"}, 32'(n_ok), 32'(tv[v].ok));
      chk({tv[v].name, "_err_crc"}, 32'(n_crc), 32'(tv[v].crc));
      chk({tv[v].name, "_err_len"}, 32'(n_len), 32'(tv[v].len));
      chk({tv[v].name, "_overrun"}, 32'(n_ovr), 32'h0);
      check_outputs(tv[v].name, tv[v].outb, tv[v].nout);
    end

    // Backpressure on byte 2 plus a byte arriving during emit
    clear_obs();
    out_ready = 1'b1;
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h69);
    chk("bp_frame_ok_aligned", 32'(frame_ok), 32'h1);
    chk("bp_valid_first", 32'(out_valid), 32'h1);
    chk("bp_data_first", 32'(out_data), 32'h11);
    idle(1);
    chk("bp_frame_ok_width", 32'(frame_ok), 32'h0);
    chk("bp_data_second", 32'(out_data), 32'h22);
    out_ready = 1'b0;
    rx_data   = 8'h55;
    rx_dv     = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      rx_dv = 1'b0;
      chk($sformatf("bp_hold_data%0d", k), 32'(out_data), 32'h22);
      chk($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'h1);
      chk($sformatf("bp_hold_last%0d", k), 32'(out_last), 32'h0);
    end
    out_ready = 1'b1;
    idle(10);
    chk("bp_overrun", 32'(n_ovr), 32'h1);
    chk("bp_frame_ok_count", 32'(n_ok), 32'h1);
    chk("bp_valid_dropped", 32'(out_valid), 32'h0);
    check_outputs("bp", 128'({8'h11, 8'h22, 8'h33}), 3);

    // Reset mid-frame: the tail of the old frame must be ignored
    clear_obs();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22);
    rst_n = 1'b0;
    idle(1);
    chk("rstmid_valid", 32'(out_valid), 32'h0);
    chk("rstmid_pulses", 32'({frame_ok, err_crc, err_len, err_timeout, overrun}), 32'h0);
    rst_n = 1'b1;
    send_byte(8'h33); send_byte(8'h69);
    idle(10);
    chk("rstmid_no_events", 32'(n_ok + n_crc + n_len + n_ovr + n_to), 32'h0);
    chk("rstmid_no_output", 32'(got.size()), 32'h0);
    clear_obs();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42); send_byte(8'h43);
    idle(10);
    chk("rstmid_recover_ok", 32'(n_ok), 32'h1);
    check_outputs("rstmid_recover", 128'(8'h42), 1);

    // Reset while emitting
    clear_obs();
    out_ready = 1'b0;
    send_byte(8'hA5); send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h32);
    chk("rstemit_valid_before", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    idle(1);
    chk("rstemit_valid", 32'(out_valid), 32'h0);
    chk("rstemit_data", 32'(out_data), 32'h0);
    chk("rstemit_last", 32'(out_last), 32'h0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(10);
    chk("rstemit_no_output", 32'(got.size()), 32'h0);
    chk("rstemit_no_errors", 32'(n_crc + n_len + n_ovr + n_to), 32'h0);

    // Short silence mid-frame must not abort the frame
    clear_obs();
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
    idle(200);
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
    idle(10);
    chk("gap_no_timeout", 32'(n_to), 32'h0);
    chk("gap_frame_ok", 32'(n_ok), 32'h1);
    check_outputs("gap", 128'({8'h11, 8'h22, 8'h33}), 3);

`ifdef SERIAL_FRAME_TIMEOUT_EN
    begin
      longint n;
      clear_obs();
      send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
      n = 0;
      while (!err_timeout && n < TO + 20) begin
        @(posedge clk); #1;
        n++;
      end
      chk("to_cycles", 32'(n), 32'(TO));
      idle(2);
      chk("to_pulse_count", 32'(n_to), 32'h1);
      chk("to_no_other", 32'(n_ok + n_crc + n_len), 32'h0);
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h7E); send_byte(8'h7F);
      idle(10);
      chk("to_recover_ok", 32'(n_ok), 32'h1);
      check_outputs("to_recover", 128'(8'h7E), 1);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
